// File: rtl/dmem_arbiter_if.sv
// Shared types and the requester/DMEM bus bundle for the data-memory arbiter.
package dmem_arbiter_pkg;

  // One requester's access descriptor as captured at grant time
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

endpackage

// Two requester ports, CPU stall and the single-port DMEM side.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 11
);
  // Port 0: CPU load/store
  logic          m0_req;
  logic          m0_we;
  logic [31:0]   m0_addr;
  logic [31:0]   m0_wdata;
  logic          m0_ack;
  logic [31:0]   m0_rdata;
  logic          m0_err;

  // Port 1: loader / debug master
  logic          m1_req;
  logic          m1_we;
  logic [31:0]   m1_addr;
  logic [31:0]   m1_wdata;
  logic          m1_ack;
  logic [31:0]   m1_rdata;
  logic          m1_err;

  logic          cpu_stall;

  // DMEM side
  logic          dmem_rena;
  logic          dmem_wena;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [31:0]   dmem_rdata;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rdata, m1_err,
    output cpu_stall,
    output dmem_rena, dmem_wena, dmem_addr, dmem_wdata,
    input  dmem_rdata
  );

  // Requester / memory-model side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata, m1_err,
    input  cpu_stall,
    input  dmem_rena, dmem_wena, dmem_addr, dmem_wdata,
    output dmem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port DMEM: IDLE grants, ACCESS drives
// the memory, RESP returns a one-cycle ack with read data or an address fault.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned   AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned   WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [29:0]   DEPTH_W  = 30'(DEPTH_WORDS);

  state_t          state_q;
  state_t          state_d;
  logic [WW-1:0]   wait_cnt;
  logic [WW-1:0]   wait_cnt_d;

  // Granted port and its fault flag, held from grant through RESP
  logic            id_q;
  logic            id_d;
  logic            fault_q;
  logic            fault_d;

  logic            any_req_c;
  logic            win1_c;
  logic            grant_c;
  logic            grant1_c;
  mreq_t           win_c;
  logic [31:0]     off_c;
  logic            fault_c;
  logic [31:0]     rdata_c;

  // Next values of the registered outputs
  logic            rena_d;
  logic            wena_d;
  logic [AW-1:0]   addr_d;
  logic [31:0]     wdata_d;
  logic            ack0_d;
  logic            ack1_d;
  logic [31:0]     rdata0_d;
  logic [31:0]     rdata1_d;
  logic            err0_d;
  logic            err1_d;

  // CPU is stalled while its request is outstanding and not yet acknowledged
  assign bus.cpu_stall = bus.m0_req & ~bus.m0_ack;

  // Winner selection and address translation of the winner's request
  always_comb begin
    any_req_c = bus.m0_req | bus.m1_req;
    if (bus.m1_req && (wait_cnt == WAIT_MAX)) begin
      win1_c = 1'b1;
    end else if (bus.m0_req) begin
      win1_c = 1'b0;
    end else begin
      win1_c = 1'b1;
    end
    grant_c  = (state_q == S_IDLE) && any_req_c;
    grant1_c = grant_c && win1_c;

    if (win1_c) begin
      win_c.we    = bus.m1_we;
      win_c.addr  = bus.m1_addr;
      win_c.wdata = bus.m1_wdata;
    end else begin
      win_c.we    = bus.m0_we;
      win_c.addr  = bus.m0_addr;
      win_c.wdata = bus.m0_wdata;
    end

    off_c   = win_c.addr - BASE_ADDR;
    fault_c = (win_c.addr < BASE_ADDR)
            || (off_c[1:0] != 2'b00)
            || (off_c[31:2] >= DEPTH_W);
  end

  // Load data is only sampled when a read was actually issued
  assign rdata_c = bus.dmem_rena ? bus.dmem_rdata : 32'h0;

  // Port-1 starvation counter: clears on no request or grant, else saturates
  always_comb begin
    wait_cnt_d = wait_cnt;
    if (!bus.m1_req || grant1_c) begin
      wait_cnt_d = '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt_d = wait_cnt + WW'(1);
    end
  end

  // Wait counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_d;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req_c) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: DMEM strobes are set up at grant so they are registered
  // for exactly the ACCESS cycle; acks are set up in ACCESS for the RESP cycle
  always_comb begin
    id_d     = id_q;
    fault_d  = fault_q;
    rena_d   = 1'b0;
    wena_d   = 1'b0;
    addr_d   = '0;
    wdata_d  = 32'h0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = 32'h0;
    rdata1_d = 32'h0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_c) begin
          id_d    = win1_c;
          fault_d = fault_c;
          rena_d  = ~fault_c & ~win_c.we;
          wena_d  = ~fault_c &  win_c.we;
          addr_d  = off_c[AW+1:2];
          wdata_d = win_c.wdata;
        end
      end
      S_ACCESS: begin
        if (id_q) begin
          ack1_d   = 1'b1;
          rdata1_d = rdata_c;
          err1_d   = fault_q;
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = rdata_c;
          err0_d   = fault_q;
        end
      end
      default: ;
    endcase
  end

  // Output and latched-request registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_q           <= 1'b0;
      fault_q        <= 1'b0;
      bus.dmem_rena  <= 1'b0;
      bus.dmem_wena  <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= 32'h0;
      bus.m0_ack     <= 1'b0;
      bus.m0_rdata   <= 32'h0;
      bus.m0_err     <= 1'b0;
      bus.m1_ack     <= 1'b0;
      bus.m1_rdata   <= 32'h0;
      bus.m1_err     <= 1'b0;
    end else begin
      id_q           <= id_d;
      fault_q        <= fault_d;
      bus.dmem_rena  <= rena_d;
      bus.dmem_wena  <= wena_d;
      bus.dmem_addr  <= addr_d;
      bus.dmem_wdata <= wdata_d;
      bus.m0_ack     <= ack0_d;
      bus.m0_rdata   <= rdata0_d;
      bus.m0_err     <= err0_d;
      bus.m1_ack     <= ack1_d;
      bus.m1_rdata   <= rdata1_d;
      bus.m1_err     <= err1_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (DMEM).
- Port 0 is the CPU load/store port; port 1 is a secondary master such as a program/data loader or debug port.
- Translates byte addresses into DMEM word indices (base-relative) and range-checks them.
- Performs one DMEM access per grant through a 3-state FSM and returns read data with a one-cycle ack pulse.

Parameters:
BASE_ADDR, 32'h10010000, byte address of DMEM word 0
DEPTH_WORDS, 2048, number of DMEM words; index width AW = 11
MAX_WAIT, 4, cycles port 1 may be denied before it gets forced priority

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
m0_req  in  1  CPU request; held until m0_ack
m0_we  in  1  1=store, 0=load
m0_addr  in  32  CPU byte address
m0_wdata  in  32  CPU store data
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  32  load data, valid while m0_ack=1
m0_err  out  1  address fault, valid while m0_ack=1
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err  same directions, widths and meanings for port 1
cpu_stall  out  1  combinational m0_req & ~m0_ack
dmem_rena  out  1  DMEM read enable
dmem_wena  out  1  DMEM write enable
dmem_addr  out  AW  DMEM word index
dmem_wdata  out  32  DMEM write data
dmem_rdata  in  32  DMEM read data, combinational from dmem_addr

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-low. When rst=0 at a rising edge:
  - FSM goes to IDLE and wait_cnt clears to 0.
  - All outputs (acks, errs, rdata, dmem_* and the latched registers) go to 0.
  - Reset mid-access aborts the access; no write is issued in the reset cycle or later.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Selects a winner only if some req=1; otherwise stays in IDLE.
  - Winner is port 1 if m1_req=1 and wait_cnt==MAX_WAIT, else port 0 if m0_req=1, else port 1.
  - Latches the winner's id, we, addr and wdata; next state is ACCESS.
- ACCESS:
  - Computes off = addr - BASE_ADDR (32-bit unsigned).
  - fault = (addr < BASE_ADDR) | (off[1:0] != 0) | (off[31:2] >= DEPTH_WORDS).
  - dmem_addr = off[AW+1:2] and dmem_wdata = latched wdata.
  - If no fault: dmem_wena = we, dmem_rena = ~we. If fault: both enables are 0.
  - Registers rdata_q = (fault | we) ? 0 : dmem_rdata, and err_q = fault. Next state is RESP.
- RESP:
  - The winner's ack=1 for exactly this cycle, with rdata = rdata_q and err = err_q; the other port's ack, rdata and err stay 0.
  - Next state is IDLE.
- Outside ACCESS, dmem_rena, dmem_wena, dmem_addr and dmem_wdata are 0.
- Latency: req high at edge N (FSM in IDLE) gives ack high in cycle N+2; next earliest grant at edge N+3. Throughput is one access per 3 cycles.
- Handshake:
  - Requester holds req, we, addr and wdata stable from assertion through its ack cycle.
  - Requester must deassert req at the edge that samples ack=1, unless it is issuing a new request. Req high in the cycle after ack counts as a new request.
  - Req changes while the FSM is outside IDLE are ignored until IDLE.
- wait_cnt (width sized for MAX_WAIT), updated every cycle:
  - Cleared if m1_req=0 or port 1 is granted this cycle.
  - Otherwise increments, saturating at MAX_WAIT.
- Simultaneous requests:
  - Port 0 wins until port 1 has been denied MAX_WAIT cycles, then port 1 wins once.
  - Port 0 is never starved: at most one port-1 access lies between consecutive port-0 grants when port 0 requests continuously.
- Store with fault: no write, err=1. Load with fault: rdata=0, err=1.

Test Plan:
- Single load: DMEM word 3 preloaded 32'hDEADBEEF; m0 load addr 32'h1001000C at edge 0 -> dmem_rena=1 with dmem_addr=3 in cycle 1; m0_ack=1, m0_rdata=32'hDEADBEEF, m0_err=0 in cycle 2.
- Store then load: m0 store addr 32'h10010010, wdata 32'h12345678 -> dmem_wena=1 with dmem_addr=4 for one cycle, m0_rdata=0 on ack; subsequent load of the same address returns 32'h12345678.
- Faults:
  - addr 32'h1000FFFC -> err=1, no enables.
  - addr 32'h10010002 -> err=1, no enables.
  - addr 32'h10012000 (index 2048) -> err=1, no enables.
  - addr 32'h10011FFC -> index 2047 accepted, err=0.
- Contention with MAX_WAIT=4: m0_req and m1_req both held continuously, m0 reissuing after each ack -> m0 granted first; m1 granted once wait_cnt reaches 4, then m0 again; cpu_stall high whenever m0_req=1 and m0_ack=0.
- Reset mid-op: m1 store issued, rst=0 asserted during the ACCESS-preceding IDLE edge -> no dmem_wena pulse, all outputs 0 next cycle, FSM in IDLE, wait_cnt=0; after rst=1 a fresh m0 load completes normally with 2-cycle latency.
